// File: rtl/alu_pkg.sv
// alu_pkg: shared mode encodings, flag bit positions and FSM state type for the sequential ALU.
package alu_pkg;
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SHL   = 4'b0101;
    localparam logic [3:0] ALU_SHR   = 4'b0110;
    localparam logic [3:0] ALU_MUL   = 4'b0111;
    localparam logic [3:0] ALU_DIV   = 4'b1000;
    localparam logic [3:0] ALU_PASSA = 4'b1001;
    localparam logic [3:0] ALU_REM   = 4'b1010;
    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_NEG   = 2;
    localparam int FLG_OVF   = 3;
    localparam int FLG_PAR   = 4;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned shift-add multiplier and restoring divider.
// lo_o/hi_o carry the next-step values so the caller can capture the result on the last step.
module alu_muldiv_iter import alu_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);
    localparam int CW = $clog2(WIDTH);
    logic             run_q, mul_q, ge;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, m_q, diff;
    logic [WIDTH:0]   sum, rem_t;
    // MUL: {hi,lo} holds partial product and multiplier; DIV: hi is the remainder, lo shifts dividend out and quotient in
    always_comb begin
        sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        rem_t = {hi_q, lo_q[WIDTH-1]};
        ge    = rem_t >= {1'b0, m_q};
        diff  = rem_t[WIDTH-1:0] - m_q;
        hi_o  = mul_q ? sum[WIDTH:1] : (ge ? diff : rem_t[WIDTH-1:0]);
        lo_o  = mul_q ? {sum[0], lo_q[WIDTH-1:1]} : {lo_q[WIDTH-2:0], ge};
    end
    assign done_o = run_q && cnt_q == CW'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            mul_q <= 1'b0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
        end else if (go_i) begin
            run_q <= 1'b1;
            mul_q <= op_i == ALU_MUL;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= a_i;
            m_q   <= b_i;
        end else if (run_q) begin
            run_q <= !done_o;
            cnt_q <= cnt_q + 1'b1;
            hi_q  <= hi_o;
            lo_q  <= lo_o;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with single-cycle logic/arith ops and iterative MUL/DIV/REM
// behind a start/busy/done handshake; result and flags are registered.
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH     = 16,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    input  logic             flags_ie,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [4:0]       flags_out
);
    localparam logic [WIDTH-1:0] WMAX = WIDTH'(WIDTH);
    state_t           state_q;
    logic [3:0]       mode_q;
    logic             fie_q, bz_q, done_q, is_md, go, md_done, sc_c, sc_v, md_c, md_v;
    logic [WIDTH-1:0] out_q, sc_res, md_res, md_lo, md_hi;
    logic [WIDTH:0]   add_r, sub_r;
    logic [4:0]       flags_q;
    function automatic logic [4:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
        logic [4:0] f;
        f            = '0;
        f[FLG_ZERO]  = r == '0;
        f[FLG_CARRY] = c;
        f[FLG_NEG]   = r[WIDTH-1];
        f[FLG_OVF]   = v;
        f[FLG_PAR]   = ^r;
        return f;
    endfunction
    // with MULDIV_EN=0 the MUL/DIV/REM codes fall through to the B-pass default below
    assign is_md = MULDIV_EN && (mode == ALU_MUL || mode == ALU_DIV || mode == ALU_REM);
    assign go    = start && state_q == IDLE && is_md;
    always_comb begin
        add_r  = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, carry_in};
        sub_r  = {1'b0, a_in} - {1'b0, b_in} - {{WIDTH{1'b0}}, carry_in};
        sc_res = b_in;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (mode)
            ALU_ADD: begin
                sc_res = add_r[WIDTH-1:0];
                sc_c   = add_r[WIDTH];
                sc_v   = a_in[WIDTH-1] == b_in[WIDTH-1] && add_r[WIDTH-1] != a_in[WIDTH-1];
            end
            ALU_SUB: begin
                sc_res = sub_r[WIDTH-1:0];
                sc_c   = sub_r[WIDTH];
                sc_v   = a_in[WIDTH-1] != b_in[WIDTH-1] && sub_r[WIDTH-1] != a_in[WIDTH-1];
            end
            ALU_AND:   sc_res = a_in & b_in;
            ALU_OR:    sc_res = a_in | b_in;
            ALU_XOR:   sc_res = a_in ^ b_in;
            ALU_SHL:   sc_res = b_in < WMAX ? a_in << b_in : '0;
            ALU_SHR:   sc_res = b_in < WMAX ? a_in >> b_in : '0;
            ALU_PASSA: sc_res = a_in;
            default: ;
        endcase
    end
    assign md_res = mode_q == ALU_REM ? md_hi : md_lo;
    assign md_c   = mode_q == ALU_MUL && |md_hi;
    assign md_v   = mode_q != ALU_MUL && bz_q;
    alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk    (clk),
        .rst_n  (rst_n),
        .go_i   (go),
        .op_i   (mode),
        .a_i    (a_in),
        .b_i    (b_in),
        .done_o (md_done),
        .lo_o   (md_lo),
        .hi_o   (md_hi)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= '0;
            fie_q   <= 1'b0;
            bz_q    <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE && start) begin
                if (is_md) begin
                    state_q <= RUN;
                    mode_q  <= mode;
                    fie_q   <= flags_ie;
                    bz_q    <= b_in == '0;
                end else begin
                    out_q  <= sc_res;
                    done_q <= 1'b1;
                    if (flags_ie) flags_q <= mk_flags(sc_res, sc_c, sc_v);
                end
            end else if (state_q == RUN && md_done) begin
                state_q <= IDLE;
                out_q   <= md_res;
                done_q  <= 1'b1;
                if (fie_q) flags_q <= mk_flags(md_res, md_c, md_v);
            end
        end
    end
    assign busy      = state_q == RUN;
    assign done      = done_q;
    assign out       = out_q;
    assign flags_out = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors, hand-written handshake/reset sequences and random ops
// checked against an arithmetic reference model of the 16-bit ALU.
module tb_alu_seq;
    logic        clk, rst_n, start, carry_in, flags_ie, busy, done;
    logic [3:0]  mode;
    logic [15:0] a_in, b_in, out;
    logic [4:0]  flags_out, cur_flags;
    int          tests, fails;

    typedef struct {
        logic [3:0]  m;
        logic [15:0] a, b;
        logic        cin, fie;
        logic [15:0] eo;
        logic [4:0]  ef;
    } vec_t;
    vec_t tbl[16];

    alu_seq #(.WIDTH(16), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a_in(a_in), .b_in(b_in),
        .carry_in(carry_in), .flags_ie(flags_ie), .busy(busy), .done(done), .out(out),
        .flags_out(flags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // returns {PAR,OVF,NEG,CARRY,ZERO, result}
    function automatic logic [20:0] model(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [31:0] p;
        int          sr;
        logic [15:0] r;
        logic        c, v;
        r = b; c = 1'b0; v = 1'b0; p = '0; sr = 0;
        case (m)
            4'd0: begin
                p  = 32'(a) + 32'(b) + 32'(cin);
                r  = p[15:0];
                c  = p[16];
                sr = int'($signed(a)) + int'($signed(b)) + int'(cin);
                v  = sr > 32767 || sr < -32768;
            end
            4'd1: begin
                sr = int'(a) - int'(b) - int'(cin);
                r  = sr[15:0];
                c  = sr < 0;
                sr = int'($signed(a)) - int'($signed(b)) - int'(cin);
                v  = sr > 32767 || sr < -32768;
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = b >= 16 ? 16'd0 : a << b;
            4'd6: r = b >= 16 ? 16'd0 : a >> b;
            4'd7: begin
                p = 32'(a) * 32'(b);
                r = p[15:0];
                c = p[31:16] != 0;
            end
            4'd8:  begin r = b == 0 ? 16'hFFFF : a / b; v = b == 0; end
            4'd9:  r = a;
            4'd10: begin r = b == 0 ? a : a % b; v = b == 0; end
            default: r = b;
        endcase
        return {^r, v, r[15], c, r == 16'd0, r};
    endfunction

    task automatic run_op(input string nm, input logic [3:0] m, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic f, input logic [15:0] eo, input logic [4:0] ef);
        int cyc, nb;
        bit md;
        md = m == 4'd7 || m == 4'd8 || m == 4'd10;
        @(negedge clk);
        start = 1'b1; mode = m; a_in = a; b_in = b; carry_in = c; flags_ie = f;
        @(negedge clk);
        start = 1'b0; cyc = 1; nb = 0;
        while (!done && cyc < 40) begin
            start = 1'b0;
            if (busy) begin
                nb++;
                start = 1'($urandom_range(0, 1)); mode = 4'($urandom); a_in = 16'($urandom);
                b_in = 16'($urandom); carry_in = 1'($urandom); flags_ie = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({nm, " latency"}, cyc, md ? 17 : 1);
        check({nm, " busy cycles"}, nb, md ? 16 : 0);
        check({nm, " busy at done"}, busy, 0);
        check({nm, " out"}, out, eo);
        check({nm, " flags"}, flags_out, ef);
        cur_flags = ef;
        @(negedge clk);
        check({nm, " done pulse width"}, done, 0);
    endtask

    initial begin
        logic [20:0] r;
        logic [3:0]  m;
        logic [15:0] a, b;
        logic        c, f;
        int          ndone;
        tests = 0; fails = 0; cur_flags = '0;
        rst_n = 1'b0; start = 1'b0; mode = '0; a_in = '0; b_in = '0; carry_in = 1'b0; flags_ie = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out", out, 0);
        check("reset flags", flags_out, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst_n = 1'b1;

        tbl[0]  = '{4'd0,  16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 5'b00011};
        tbl[1]  = '{4'd1,  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 5'b11000};
        tbl[2]  = '{4'd4,  16'h00FF, 16'h0F0F, 1'b0, 1'b1, 16'h0FF0, 5'b00000};
        tbl[3]  = '{4'd7,  16'h0123, 16'h0100, 1'b0, 1'b1, 16'h2300, 5'b10010};
        tbl[4]  = '{4'd8,  16'd1000, 16'd7,    1'b0, 1'b1, 16'd142,  5'b00000};
        tbl[5]  = '{4'd10, 16'd1000, 16'd7,    1'b0, 1'b1, 16'd6,    5'b00000};
        tbl[6]  = '{4'd8,  16'd5,    16'd0,    1'b0, 1'b1, 16'hFFFF, 5'b01100};
        tbl[7]  = '{4'd2,  16'hF0F0, 16'h0F0F, 1'b0, 1'b0, 16'h0000, 5'b01100};
        tbl[8]  = '{4'd5,  16'h0001, 16'd16,   1'b0, 1'b1, 16'h0000, 5'b00001};
        tbl[9]  = '{4'd6,  16'h8000, 16'd15,   1'b0, 1'b1, 16'h0001, 5'b10000};
        tbl[10] = '{4'd10, 16'd5,    16'd0,    1'b0, 1'b1, 16'h0005, 5'b01000};
        tbl[11] = '{4'd9,  16'h8001, 16'hFFFF, 1'b0, 1'b1, 16'h8001, 5'b00100};
        tbl[12] = '{4'd15, 16'h1234, 16'h0007, 1'b0, 1'b1, 16'h0007, 5'b10000};
        tbl[13] = '{4'd0,  16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 5'b11100};
        tbl[14] = '{4'd1,  16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 5'b00110};
        tbl[15] = '{4'd3,  16'h1200, 16'h0034, 1'b0, 1'b1, 16'h1234, 5'b10000};
        foreach (tbl[i])
            run_op($sformatf("vec%0d", i), tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].fie, tbl[i].eo, tbl[i].ef);

        // back-to-back single-cycle ops
        @(negedge clk);
        start = 1'b1; mode = 4'd1; a_in = 16'h8000; b_in = 16'h0001; carry_in = 1'b0; flags_ie = 1'b1;
        @(negedge clk);
        check("b2b sub done", done, 1);
        check("b2b sub out", out, 16'h7FFF);
        check("b2b sub flags", flags_out, 5'b11000);
        mode = 4'd4; a_in = 16'h00FF; b_in = 16'h0F0F;
        @(negedge clk);
        start = 1'b0;
        check("b2b xor done", done, 1);
        check("b2b xor out", out, 16'h0FF0);
        check("b2b xor flags", flags_out, 5'b00000);
        @(negedge clk);
        check("b2b idle done", done, 0);
        cur_flags = '0;

        for (int i = 0; i < 150; i++) begin
            m = 4'($urandom);
            a = 16'($urandom);
            b = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 20)) : 16'($urandom);
            c = 1'($urandom);
            f = 1'($urandom);
            r = model(m, a, b, c);
            run_op($sformatf("rnd%0d m%0d", i, m), m, a, b, c, f, r[15:0], f ? r[20:16] : cur_flags);
        end

        // reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; mode = 4'd7; a_in = 16'h0123; b_in = 16'h0100; flags_ie = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-abort busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort out", out, 0);
        check("abort flags", flags_out, 0);
        check("abort done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no done after abort", ndone, 0);
        cur_flags = '0;
        run_op("post-reset div", 4'd8, 16'd1000, 16'd7, 1'b0, 1'b1, 16'd142, 5'b00000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised successor to the CPU's single-cycle 16-bit ALU. Adds generic data width, multi-cycle unsigned multiply, divide and remainder, and a start/busy/done handshake. Registered result and flags register. Sits in the execute stage; the control unit stalls on busy.

Parameters:
WIDTH, 16, datapath width in bits (>=4)
MULDIV_EN, 1, 1 = MUL/DIV/REM implemented; 0 = those modes behave as B PASS, single-cycle

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  accept operation this cycle (ignored while busy=1)
mode  in  4  operation select, sampled with start
a_in  in  WIDTH  operand A, sampled with start
b_in  in  WIDTH  operand B, sampled with start
carry_in  in  1  carry/borrow in for ADD/SUB, sampled with start
flags_ie  in  1  update flags on completion, sampled with start
busy  out  1  multi-cycle operation in progress
done  out  1  one-cycle pulse: out/flags_out valid from this cycle
out  out  WIDTH  result, held until next done
flags_out  out  5  {PAR,OVF,NEG,CARRY,ZERO}, held unless updated

Behaviour:
- Reset (async, rst_n=0): out=0, flags_out=0, busy=0, done=0, FSM=IDLE, iteration counter=0.
- Mode encoding: 0000 ADD a+b+cin; 0001 SUB a-b-cin; 0010 AND; 0011 OR; 0100 XOR; 0101 SHL a<<b; 0110 SHR a>>b (logical); 0111 MUL low WIDTH bits; 1000 DIV unsigned quotient; 1001 A PASS; 1010 REM unsigned remainder; others B PASS.
- Shift amounts >= WIDTH give 0.
- Single-cycle ops (all except MUL/DIV/REM): start in cycle N -> out, done=1 in cycle N+1; busy stays 0. start in N+1 is accepted (back-to-back, one result per cycle).
- Multi-cycle ops: FSM IDLE -> RUN on start. RUN iterates WIDTH cycles: shift-add for MUL, restoring shift-subtract for DIV/REM. busy=1 in cycles N+1..N+WIDTH. FSM -> IDLE with done=1 and busy=0 in cycle N+WIDTH+1. start asserted while busy=1 is dropped, with no side effects.
- Result is computed from operands sampled at start; input changes during RUN have no effect.
- Flags are computed on the final result and written to flags_out in the done cycle only if flags_ie was 1 at start.
  - ZERO = result==0
  - NEG = result[WIDTH-1]
  - PAR = XOR of result bits
  - CARRY: ADD = carry out of bit WIDTH-1; SUB = borrow; MUL = 1 if the upper WIDTH product bits are nonzero; else 0.
  - OVF: ADD/SUB = signed overflow of the two's-complement operation; DIV/REM = 1 on divide by zero; else 0.
- Divide by zero (b=0): still takes the full WIDTH cycles. DIV result = all ones; REM result = a_in; OVF=1.
- ADD with a=all ones, b=0, cin=1: result 0, ZERO=1, CARRY=1.
- rst_n asserted mid-RUN: abort immediately, all outputs go to reset values, no done pulse.

Decomposition:
- Package alu_pkg: mode constants (ALU_ADD..ALU_REM), flag bit indices (FLG_ZERO=0, FLG_CARRY=1, FLG_NEG=2, FLG_OVF=3, FLG_PAR=4), FSM state type {IDLE, RUN}.
- Sub-module alu_muldiv_iter: the iterative multiplier/divider with its own counter. Interface: go, op, a, b -> done_i, lo, hi/rem. Top holds the single-cycle datapath, FSM, result and flags registers.

Test Plan (WIDTH=16):
- ADD a=0xFFFF, b=0x0000, cin=1, flags_ie=1 -> done at N+1, out=0x0000, flags_out=5'b00011 (ZERO, CARRY).
- SUB a=0x8000, b=0x0001, cin=0 -> out=0x7FFF, OVF=1, NEG=0, CARRY=0, PAR=1; then back-to-back XOR 0x00FF^0x0F0F next cycle -> out=0x0FF0.
- MUL a=0x0123, b=0x0100 -> busy N+1..N+16, done N+17, out=0x2300, CARRY=1 (high part 0x0001); start pulses during busy are ignored.
- DIV a=1000, b=7 -> out=142; REM same operands -> out=6; DIV a=5, b=0 -> out=0xFFFF, OVF=1.
- flags_ie=0 on an op yielding 0 -> flags_out unchanged from the previous value, out updated.
- rst_n low at N+5 of a MUL -> busy=0, out=0, flags_out=0 immediately; no done pulse after release.
